// File: rtl/instruction_cache_if.sv
// Fetch-side and instruction-memory-side signals of the instruction cache.
// The hit_count/miss_count statistics exist only when ICACHE_STATS_EN is defined.
interface instruction_cache_if;
    logic [31:0]  pc;
    logic         fetch_req;
    logic [31:0]  instruction;
    logic         instruction_valid;
    logic         stall;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic [127:0] mem_data_line;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    modport master (
        output pc, fetch_req, mem_data_line,
        input  instruction, instruction_valid, stall, mem_address, mem_read,
        input  hit_count, miss_count
    );
    modport slave (
        input  pc, fetch_req, mem_data_line,
        output instruction, instruction_valid, stall, mem_address, mem_read,
        output hit_count, miss_count
    );
`else
    modport master (
        output pc, fetch_req, mem_data_line,
        input  instruction, instruction_valid, stall, mem_address, mem_read
    );
    modport slave (
        input  pc, fetch_req, mem_data_line,
        output instruction, instruction_valid, stall, mem_address, mem_read
    );
`endif
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with 128-bit lines and a fixed-latency fill.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module instruction_cache #(
    parameter int NUM_LINES   = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic               clock,
    input  logic               reset,
    instruction_cache_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - 4 - IDX_W;
    localparam logic [3:0] MEM_LAT4 = 4'(MEM_LATENCY);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FILL    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    logic [1:0]           r_state;
    logic [3:0]           r_lat_cnt;
    logic [NUM_LINES-1:0] r_valid;
    logic [127:0]         r_data [NUM_LINES];
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [1:0]           r_offset;
    logic [31:0]          r_mem_address;
    logic                 r_mem_read;
    logic                 r_stall;
    logic [31:0]          r_instruction;
    logic                 r_instruction_valid;

    logic [1:0]           w_state_nxt;
    logic [3:0]           w_lat_nxt;
    logic [3:0]           w_lat_inc;
    logic                 w_accept_hit;
    logic                 w_accept_miss;
    logic                 w_fill_we;
    logic                 w_hit;
    logic [IDX_W-1:0]     w_req_idx;
    logic [TAG_W-1:0]     w_req_tag;
    logic [1:0]           w_req_offset;
    logic [IDX_W-1:0]     w_fill_idx;
    logic [TAG_W-1:0]     w_fill_tag;

    function automatic logic [31:0] select_word(input logic [127:0] line, input logic [1:0] offset);
        logic [31:0] word;
        case (offset)
            2'd0:    word = line[31:0];
            2'd1:    word = line[63:32];
            2'd2:    word = line[95:64];
            2'd3:    word = line[127:96];
            default: word = 32'd0;
        endcase
        return word;
    endfunction

    assign w_req_offset = bus.pc[3:2];
    assign w_req_idx    = bus.pc[4 +: IDX_W];
    assign w_req_tag    = bus.pc[31 -: TAG_W];
    assign w_fill_idx   = r_mem_address[4 +: IDX_W];
    assign w_fill_tag   = r_mem_address[31 -: TAG_W];
    assign w_hit        = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_lat_inc    = r_lat_cnt + 4'd1;

    // Next-state decode: accept hits/misses only in IDLE, count fill latency in FILL.
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_nxt     = r_lat_cnt;
        w_accept_hit  = 1'b0;
        w_accept_miss = 1'b0;
        w_fill_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fetch_req) begin
                    if (w_hit) begin
                        w_accept_hit = 1'b1;
                    end else begin
                        w_accept_miss = 1'b1;
                        w_state_nxt   = FILL;
                        w_lat_nxt     = 4'd0;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FILL: begin
                if (w_lat_inc == MEM_LAT4) begin
                    w_fill_we   = 1'b1;
                    w_state_nxt = RESPOND;
                    w_lat_nxt   = 4'd0;
                end else begin
                    w_lat_nxt = w_lat_inc;
                end
            end
            RESPOND: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_lat_nxt   = 4'd0;
            end
        endcase
    end

    // Control state, valid bits and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state             <= IDLE;
            r_lat_cnt           <= 4'd0;
            r_valid             <= '0;
            r_offset            <= 2'd0;
            r_mem_address       <= 32'd0;
            r_mem_read          <= 1'b0;
            r_stall             <= 1'b0;
            r_instruction       <= 32'd0;
            r_instruction_valid <= 1'b0;
        end else begin
            r_state             <= w_state_nxt;
            r_lat_cnt           <= w_lat_nxt;
            r_instruction_valid <= 1'b0;
            if (w_accept_hit) begin
                r_instruction_valid <= 1'b1;
                r_instruction       <= select_word(r_data[w_req_idx], w_req_offset);
            end
            if (w_accept_miss) begin
                r_offset      <= w_req_offset;
                r_mem_address <= {bus.pc[31:4], 4'b0000};
                r_mem_read    <= 1'b1;
                r_stall       <= 1'b1;
            end
            if (w_fill_we) begin
                r_valid[w_fill_idx] <= 1'b1;
                r_mem_read          <= 1'b0;
                r_stall             <= 1'b0;
            end
            // The filled line is already in the array by the RESPOND cycle.
            if (r_state == RESPOND) begin
                r_instruction_valid <= 1'b1;
                r_instruction       <= select_word(r_data[w_fill_idx], r_offset);
            end
        end
    end

    // Line data and tags are not reset; a reset in the fill's last cycle suppresses the write.
    always_ff @(posedge clock) begin
        if (w_fill_we && !reset) begin
            r_data[w_fill_idx] <= bus.mem_data_line;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

    assign bus.instruction       = r_instruction;
    assign bus.instruction_valid = r_instruction_valid;
    assign bus.stall             = r_stall;
    assign bus.mem_address       = r_mem_address;
    assign bus.mem_read          = r_mem_read;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Accepted hit/miss counters, wrapping naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_accept_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_accept_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Randomised bench for instruction_cache against a transaction-level cache model,
// plus directed sequences pinning miss/hit timing, conflicts, reset abort and ignored requests.
module tb_instruction_cache;
    localparam int NL = 8;
    localparam int ML = 2;
    localparam int IW = $clog2(NL);

    logic clock;
    logic reset;
    instruction_cache_if bus_if ();

    instruction_cache #(.NUM_LINES(NL), .MEM_LATENCY(ML)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    int          cyc = 0;
    int          fill_cyc, resp_cyc;
    int          free_cyc = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    logic [1:0]  pend_off;
    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];
    int          m_hits = 0;
    int          m_misses = 0;
    logic        exp_valid, exp_stall, exp_mread;
    logic [31:0] exp_instr, exp_maddr;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a ^ 32'hDEAD0003, a ^ 32'hC0DE0002, a ^ 32'hBEEF0001, a ^ 32'hFACE0000};
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a, input logic [1:0] off);
        logic [127:0] l;
        l = line_of(a);
        return l[off*32 +: 32];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        int idx;
        logic [31:0] tag;
        cyc++;
        if (reset) begin
            for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
            pend = 1'b0; free_cyc = 0;
            exp_valid = 1'b0; exp_stall = 1'b0; exp_mread = 1'b0;
            exp_instr = 32'd0; exp_maddr = 32'd0;
            m_hits = 0; m_misses = 0;
        end else begin
            exp_valid = 1'b0;
            if (pend && cyc == fill_cyc) begin
                idx = int'((pend_addr >> 4) % NL);
                m_valid[idx] = 1'b1;
                m_tag[idx]   = pend_addr >> (4 + IW);
                exp_stall = 1'b0;
                exp_mread = 1'b0;
            end
            if (pend && cyc == resp_cyc) begin
                exp_valid = 1'b1;
                exp_instr = word_of(pend_addr, pend_off);
                pend = 1'b0;
            end
            if (bus_if.fetch_req && cyc >= free_cyc) begin
                idx = int'((bus_if.pc >> 4) % NL);
                tag = bus_if.pc >> (4 + IW);
                if (m_valid[idx] && m_tag[idx] == tag) begin
                    exp_valid = 1'b1;
                    exp_instr = word_of(bus_if.pc & 32'hFFFF_FFF0, 2'((bus_if.pc >> 2) & 32'd3));
                    free_cyc = cyc + 1;
                    m_hits++;
                end else begin
                    pend = 1'b1;
                    pend_addr = bus_if.pc & 32'hFFFF_FFF0;
                    pend_off  = 2'((bus_if.pc >> 2) & 32'd3);
                    fill_cyc = cyc + ML;
                    resp_cyc = cyc + ML + 1;
                    free_cyc = cyc + ML + 2;
                    exp_stall = 1'b1;
                    exp_mread = 1'b1;
                    exp_maddr = pend_addr;
                    m_misses++;
                end
            end
        end
    endtask

    // One clock: update model at the edge, then present memory data (junk unless due this edge).
    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        if (pend && (cyc + 1) == fill_cyc) bus_if.mem_data_line = line_of(pend_addr);
        else bus_if.mem_data_line = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Issue one request and wait (bounded) for its instruction_valid.
    task automatic req(input logic [31:0] p, input bit noise, output logic st,
                       output logic [31:0] ma, output int lat, output logic [31:0] w);
        bus_if.fetch_req = 1'b1;
        bus_if.pc = p;
        step();
        bus_if.fetch_req = 1'b0;
        #2;
        st = bus_if.stall;
        ma = bus_if.mem_address;
        lat = 1;
        while (!bus_if.instruction_valid && lat < 20) begin
            if (noise) begin
                bus_if.fetch_req = 1'b1;
                bus_if.pc = $urandom;
            end
            step();
            bus_if.fetch_req = 1'b0;
            #2;
            lat++;
        end
        w = bus_if.instruction;
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("instruction_valid", {31'd0, bus_if.instruction_valid}, {31'd0, exp_valid});
            chk("instruction", bus_if.instruction, exp_instr);
            chk("stall", {31'd0, bus_if.stall}, {31'd0, exp_stall});
            chk("mem_read", {31'd0, bus_if.mem_read}, {31'd0, exp_mread});
            if (exp_mread) chk("mem_address", bus_if.mem_address, exp_maddr);
`ifdef ICACHE_STATS_EN
            chk("hit_count", bus_if.hit_count, m_hits);
            chk("miss_count", bus_if.miss_count, m_misses);
`endif
        end
    end

    initial begin
        logic st;
        logic [31:0] ma, w;
        int lat, nv;

        reset = 1'b1;
        bus_if.fetch_req = 1'b0;
        bus_if.pc = 32'd0;
        bus_if.mem_data_line = 128'd0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        #2;
        chk("rst_instr", bus_if.instruction, 32'd0);
        chk("rst_stall", {31'd0, bus_if.stall}, 32'd0);
        chk("rst_maddr", bus_if.mem_address, 32'd0);

        // cold miss at pc=20, then hit in the same line at pc=28
        req(32'd20, 1'b0, st, ma, lat, w);
        chk("miss20_stall", {31'd0, st}, 32'd1);
        chk("miss20_maddr", ma, 32'd16);
        chk("miss20_latency", lat, ML + 2);
        chk("miss20_word", w, 32'hBEEF0011);
        req(32'd28, 1'b0, st, ma, lat, w);
        chk("hit28_stall", {31'd0, st}, 32'd0);
        chk("hit28_latency", lat, 32'd1);
        chk("hit28_word", w, 32'hDEAD0013);

        // same index, different tag evicts
        req(32'h00, 1'b0, st, ma, lat, w);
        chk("conf00_miss", {31'd0, st}, 32'd1);
        req(32'h80, 1'b0, st, ma, lat, w);
        chk("conf80_miss", {31'd0, st}, 32'd1);
        chk("conf80_word", w, 32'h4EE0080 ^ 32'hFAA00080 ^ 32'hFACE0080 ^ 32'h4EE0080 ^ 32'hFAA00080);
        req(32'h00, 1'b0, st, ma, lat, w);
        chk("conf00_remiss", {31'd0, st}, 32'd1);

        // reset in the second fill cycle aborts the fill
        bus_if.fetch_req = 1'b1;
        bus_if.pc = 32'h40;
        step();
        bus_if.fetch_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        nv = 0;
        repeat (5) begin
            step();
            #2;
            if (bus_if.instruction_valid) nv++;
        end
        chk("rst_abort_no_valid", nv, 32'd0);
        req(32'h40, 1'b0, st, ma, lat, w);
        chk("rst_abort_remiss", {31'd0, st}, 32'd1);

        // requests during a stall are ignored
        req(32'h104, 1'b1, st, ma, lat, w);
        chk("ignore_word", w, 32'hBEEF0101);
        chk("ignore_latency", lat, ML + 2);

`ifdef ICACHE_STATS_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        req(32'h00, 1'b0, st, ma, lat, w);
        req(32'h04, 1'b0, st, ma, lat, w);
        req(32'h08, 1'b0, st, ma, lat, w);
        req(32'h80, 1'b0, st, ma, lat, w);
        chk("stats_hits", bus_if.hit_count, 32'd2);
        chk("stats_misses", bus_if.miss_count, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #2;
        chk("stats_hits_rst", bus_if.hit_count, 32'd0);
        chk("stats_misses_rst", bus_if.miss_count, 32'd0);
`endif

        // randomised traffic
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus_if.fetch_req = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 15) == 0) bus_if.pc = $urandom;
            else bus_if.pc = $urandom & 32'h0000_01FF;
            step();
        end
        reset = 1'b0;
        bus_if.fetch_req = 1'b0;
        step();
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter NUM_LINES, default 8, number of direct-mapped 128-bit lines; power of two, 2..64.
REQ-002 Parameter MEM_LATENCY, default 2, cycles from mem_address/mem_read assertion to valid mem_data_line; range 1..15.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  byte address of requested instruction; bits [1:0] ignored.
REQ-006 fetch_req  input  1  fetch request strobe, sampled on rising edge.
REQ-007 instruction  output  32  fetched instruction word.
REQ-008 instruction_valid  output  1  one-cycle pulse; instruction is valid this cycle.
REQ-009 stall  output  1  high while a miss is outstanding.
REQ-010 mem_address  output  32  line address to instruction memory, low 4 bits zero.
REQ-011 mem_read  output  1  high while a line fill is in progress.
REQ-012 mem_data_line  input  128  line returned by instruction memory.
REQ-013 hit_count, miss_count  output  32 each  statistics counters, present only per REQ-033.

Function
REQ-014 Address split: offset = pc[3:2], index = pc[4+log2(NUM_LINES)-1:4], tag = remaining upper bits.
REQ-015 Word select: offset 0 selects bits [31:0], 1 [63:32], 2 [95:64], 3 [127:96].
REQ-016 States: IDLE, FILL, RESPOND.
REQ-017 IDLE, fetch_req high, line valid and tag match (hit): next cycle instruction_valid=1 with selected word; stay IDLE; latency 1 cycle.
REQ-018 IDLE, fetch_req high, miss: latch pc; next cycle enter FILL, stall=1, mem_read=1, mem_address={latched pc[31:4],4'b0000}.
REQ-019 FILL: latency counter counts 1..MEM_LATENCY; at MEM_LATENCY, mem_data_line written to line index, tag stored, valid bit set, transition to RESPOND.
REQ-020 RESPOND: instruction_valid=1 with word selected from the filled line by latched offset; stall=0, mem_read=0; return to IDLE next cycle.
REQ-021 Miss latency: instruction_valid asserted MEM_LATENCY+2 cycles after the requesting fetch_req edge.
REQ-022 While stall=1 or in RESPOND, fetch_req and pc are ignored; requester re-issues after instruction_valid.
REQ-023 mem_address and mem_read held constant throughout FILL.
REQ-024 A fill overwrites a valid line at the same index unconditionally (no write-back; read-only cache).
REQ-025 instruction holds its last value when instruction_valid=0.
REQ-026 fetch_req low in IDLE: no state change, instruction_valid=0.

Reset
REQ-027 reset high at a clock edge: state=IDLE, all valid bits cleared, latency counter 0.
REQ-028 Output reset values: instruction=0, instruction_valid=0, stall=0, mem_read=0, mem_address=0, counters=0.
REQ-029 Reset during FILL or RESPOND aborts the fill: no line written, no instruction_valid pulse.
REQ-030 reset takes priority over fetch_req in the same cycle.
REQ-031 Line data and tag arrays need not be reset; only valid bits are.

Configuration
REQ-032 Macro ICACHE_STATS_EN selects statistics.
REQ-033 ICACHE_STATS_EN defined: hit_count and miss_count ports exist; each increments by 1 per accepted hit/miss in IDLE, wraps at 2^32, cleared by reset.
REQ-034 ICACHE_STATS_EN undefined: ports and counter logic absent; all other behaviour identical.

Verification
REQ-035 Reset, then fetch_req with pc=20 -> miss: stall=1, mem_address=16, mem_read=1 for 2 cycles; instruction = mem_data_line[63:32]; instruction_valid 4 cycles after request.
REQ-036 After REQ-035, fetch_req with pc=28 -> hit: instruction = line bits [127:96] one cycle later, stall stays 0, mem_read stays 0.
REQ-037 NUM_LINES=8: fill pc=0x00, then pc=0x80 (same index 0, new tag) -> miss; re-fetch pc=0x00 -> miss again.
REQ-038 Assert reset on 2nd FILL cycle of a miss -> no instruction_valid; same pc re-fetched -> miss again.
REQ-039 pc changed and fetch_req pulsed while stall=1 -> ignored; returned word matches the original latched pc.
REQ-040 ICACHE_STATS_EN defined: sequence miss, hit, hit, miss -> hit_count=2, miss_count=2; reset -> both 0.
